// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the combinational decoder.
// Owns the program counter, drives a 1-cycle-latency synchronous instruction
// memory, presents one op per cycle and handles decoder redirects by flushing
// the sequentially fetched word as a single bubble.
module fetch_unit #(
  parameter logic [5:0]  START_PC  = 6'd0,
  parameter logic [15:0] BUBBLE_OP = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_halt,
  input  logic        i_stall,
  input  logic        i_pc_we,
  input  logic [5:0]  i_pc_in,
  input  logic [15:0] i_imem_rdata,
  output logic [5:0]  o_imem_addr,
  output logic        o_imem_en,
  output logic [15:0] o_op,
  output logic        o_op_valid,
  output logic [5:0]  o_op_pc,
  output logic        o_running,
  output logic [15:0] o_issued_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [5:0]  r_pc;
  logic [5:0]  w_pcNext;
  logic        r_opValid;
  logic        w_opValidNext;
  logic [5:0]  r_opPc;
  logic [5:0]  w_opPcNext;
  logic [15:0] r_issuedCnt;
  logic        w_issue;
  logic        w_redirect;

  // An op issues only when it is real and the downstream is not busy;
  // a redirect is honoured only on such a cycle.
  assign w_issue    = r_opValid & ~i_stall;
  assign w_redirect = w_issue & i_pc_we;

  assign o_imem_addr  = r_pc;
  assign o_imem_en    = (r_state == RUN) & ~i_stall;
  assign o_op         = r_opValid ? i_imem_rdata : BUBBLE_OP;
  assign o_op_valid   = r_opValid;
  assign o_op_pc      = r_opPc;
  assign o_running    = (r_state == RUN);
  assign o_issued_cnt = r_issuedCnt;

  // State, pc and op tracking registers; reset returns everything at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pc      <= START_PC;
      r_opValid <= 1'b0;
      r_opPc    <= 6'd0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_opValid <= w_opValidNext;
      r_opPc    <= w_opPcNext;
    end
  end

  // Next-state logic: sequential fetch, stall hold, redirect flush and halt.
  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_opValidNext = r_opValid;
    w_opPcNext    = r_opPc;
    case (r_state)
      IDLE, HALTED: begin
        w_opValidNext = 1'b0;
        if (i_start) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (i_halt) begin
          // Current op may still issue; the in-flight fetch is dropped and
          // pc stays put so resuming refetches it.
          w_stateNext   = HALTED;
          w_opValidNext = 1'b0;
          if (w_redirect) begin
            w_pcNext = i_pc_in;
          end
        end else if (!i_stall) begin
          w_opPcNext = r_pc;
          if (w_redirect) begin
            w_pcNext      = i_pc_in;
            w_opValidNext = 1'b0;
          end else begin
            w_pcNext      = r_pc + 6'd1;
            w_opValidNext = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext   = IDLE;
        w_opValidNext = 1'b0;
      end
    endcase
  end

  // Issued-instruction counter, wrapping naturally at 16 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_issuedCnt <= 16'd0;
    end else if (w_issue) begin
      r_issuedCnt <= r_issuedCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the expected issue
// stream, a monitor pops and compares each op the DUT issues.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        stall;
  logic        pc_we;
  logic [5:0]  pc_in;
  logic [15:0] imem_rdata;
  logic [5:0]  imem_addr;
  logic        imem_en;
  logic [15:0] op;
  logic        op_valid;
  logic [5:0]  op_pc;
  logic        running;
  logic [15:0] issued_cnt;

  logic [15:0] mem [64];
  logic        redirEn;
  logic [5:0]  redirFrom;
  logic [5:0]  redirTo;

  int compared   = 0;
  int mismatched = 0;
  logic [5:0] expQ [$];

  fetch_unit #(.START_PC(6'd0), .BUBBLE_OP(16'h0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_halt(halt),
    .i_stall(stall), .i_pc_we(pc_we), .i_pc_in(pc_in),
    .i_imem_rdata(imem_rdata), .o_imem_addr(imem_addr), .o_imem_en(imem_en),
    .o_op(op), .o_op_valid(op_valid), .o_op_pc(op_pc), .o_running(running),
    .o_issued_cnt(issued_cnt)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory with 1-cycle read latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  // Decoder stand-in: redirect when the chosen op is presented
  assign pc_we = redirEn && op_valid && (op_pc == redirFrom);
  assign pc_in = redirTo;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every issued op is compared against the queued expectation
  always @(negedge clk) begin
    #3;
    if (rst_n && op_valid && !stall) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_issue: got op_pc %0d expected none", op_pc);
      end else begin
        logic [5:0] e;
        e = expQ.pop_front();
        checkOutput("issue_pc", {26'd0, op_pc}, {26'd0, e});
        checkOutput("issue_op", {16'd0, op}, {16'd0, 16'h1000 + {10'd0, e}});
      end
    end
  end

  // Advance to the input-drive slot of the next cycle
  task automatic applyStimulus;
    @(negedge clk);
    #2;
  endtask

  task automatic pushRange(input int first, input int last);
    for (int k = first; k <= last; k++) expQ.push_back(k[5:0]);
  endtask

  task automatic waitOp(input logic [5:0] pc);
    bit seen;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      applyStimulus();
      if (op_valid && op_pc == pc) seen = 1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout_op_pc: got none expected %0d", pc);
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 16'h1000 + k[15:0];
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
    redirEn = 1'b0; redirFrom = 6'd0; redirTo = 6'd0;
    #23;
    checkOutput("rst_op_valid", {31'd0, op_valid}, 32'd0);
    checkOutput("rst_imem_en", {31'd0, imem_en}, 32'd0);
    checkOutput("rst_running", {31'd0, running}, 32'd0);
    checkOutput("rst_op", {16'd0, op}, 32'd0);
    checkOutput("rst_cnt", {16'd0, issued_cnt}, 32'd0);
    checkOutput("rst_addr", {26'd0, imem_addr}, 32'd0);
    applyStimulus();
    rst_n = 1'b1;

    // Phase A: sequential run, stall at 7, halt at 12, resume
    pushRange(0, 15);
    applyStimulus();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    #1;
    checkOutput("fill1_running", {31'd0, running}, 32'd1);
    checkOutput("fill1_en", {31'd0, imem_en}, 32'd1);
    checkOutput("fill1_valid", {31'd0, op_valid}, 32'd0);
    applyStimulus();
    checkOutput("fill2_valid", {31'd0, op_valid}, 32'd1);
    checkOutput("fill2_pc", {26'd0, op_pc}, 32'd0);

    waitOp(6'd7);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) applyStimulus();
      #1;
      checkOutput("stall_pc", {26'd0, op_pc}, 32'd7);
      checkOutput("stall_op", {16'd0, op}, 32'h1007);
      checkOutput("stall_cnt", {16'd0, issued_cnt}, 32'd7);
      checkOutput("stall_en", {31'd0, imem_en}, 32'd0);
    end
    applyStimulus();
    stall = 1'b0;
    applyStimulus();
    checkOutput("unstall_pc", {26'd0, op_pc}, 32'd8);
    checkOutput("unstall_cnt", {16'd0, issued_cnt}, 32'd8);

    waitOp(6'd10);
    checkOutput("cnt_at10", {16'd0, issued_cnt}, 32'd10);

    waitOp(6'd12);
    halt = 1'b1;
    applyStimulus();
    halt = 1'b0;
    #1;
    checkOutput("halt_running", {31'd0, running}, 32'd0);
    checkOutput("halt_valid", {31'd0, op_valid}, 32'd0);
    checkOutput("halt_op", {16'd0, op}, 32'd0);
    checkOutput("halt_cnt", {16'd0, issued_cnt}, 32'd13);
    repeat (3) applyStimulus();
    checkOutput("halted_en", {31'd0, imem_en}, 32'd0);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    #1;
    checkOutput("resume1_valid", {31'd0, op_valid}, 32'd0);
    checkOutput("resume1_en", {31'd0, imem_en}, 32'd1);
    applyStimulus();
    checkOutput("resume2_valid", {31'd0, op_valid}, 32'd1);
    checkOutput("resume2_pc", {26'd0, op_pc}, 32'd13);

    // Asynchronous reset between edges while op 16 is presented
    waitOp(6'd16);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, op_valid}, 32'd0);
    checkOutput("arst_en", {31'd0, imem_en}, 32'd0);
    checkOutput("arst_cnt", {16'd0, issued_cnt}, 32'd0);
    checkOutput("arst_running", {31'd0, running}, 32'd0);
    applyStimulus();
    rst_n = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("post_rst_addr", {26'd0, imem_addr}, 32'd0);
    checkOutput("post_rst_running", {31'd0, running}, 32'd0);
    checkOutput("post_rst_valid", {31'd0, op_valid}, 32'd0);

    // Phase B: redirect 5 -> 40, then wrap through 63
    redirEn = 1'b1; redirFrom = 6'd5; redirTo = 6'd40;
    pushRange(0, 5);
    pushRange(40, 63);
    pushRange(0, 2);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    waitOp(6'd5);
    applyStimulus();
    checkOutput("bubble_valid", {31'd0, op_valid}, 32'd0);
    checkOutput("bubble_op", {16'd0, op}, 32'd0);
    checkOutput("bubble_cnt", {16'd0, issued_cnt}, 32'd6);
    applyStimulus();
    checkOutput("target_valid", {31'd0, op_valid}, 32'd1);
    checkOutput("target_pc", {26'd0, op_pc}, 32'd40);
    checkOutput("target_op", {16'd0, op}, 32'h1028);
    redirEn = 1'b0;

    waitOp(6'd62);
    for (int i = 0; i < 4; i++) begin
      logic [5:0] w;
      w = 6'd62 + i[5:0];
      if (i != 0) applyStimulus();
      checkOutput("wrap_valid", {31'd0, op_valid}, 32'd1);
      checkOutput("wrap_pc", {26'd0, op_pc}, {26'd0, w});
    end
    applyStimulus();
    checkOutput("wrap_cnt", {16'd0, issued_cnt}, 32'd32);
    halt = 1'b1;
    applyStimulus();
    halt = 1'b0;
    #1;
    checkOutput("final_cnt", {16'd0, issued_cnt}, 32'd33);
    checkOutput("final_running", {31'd0, running}, 32'd0);
    repeat (3) applyStimulus();
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational decoder.
- Owns the 6-bit program counter and drives a synchronous instruction memory with 1-cycle read latency.
- Presents one 16-bit op per cycle to the decoder, and takes the decoder's pc_we/pc_in redirects with a one-bubble flush.
- Provides run/halt control, stall hold and a 16-bit issued-instruction counter.

Parameters:
START_PC, 6'd0, PC value loaded on reset
BUBBLE_OP, 16'h0000, op driven whenever op_valid=0; downstream gates reg_we/mem_we with op_valid

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; IDLE/HALTED -> RUN
halt  in  1  single-cycle pulse; RUN -> HALTED
stall  in  1  freeze fetch and hold current op (downstream busy)
pc_we  in  1  redirect request from decoder (combinational on op)
pc_in  in  6  redirect target from decoder
imem_rdata  in  16  instruction memory read data, valid 1 cycle after an enabled address
imem_addr  out  6  instruction memory address (= pc register)
imem_en  out  1  instruction memory read enable
op  out  16  instruction to decoder
op_valid  out  1  op is a real instruction to execute this cycle
op_pc  out  6  address of current op
running  out  1  state==RUN
issued_cnt  out  16  count of issued instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=START_PC, op_valid=0, op_pc=0, issued_cnt=0.
  - Outputs: imem_en=0, op=BUBBLE_OP, running=0.
- States are IDLE, RUN and HALTED, encoded in 2 bits.
- IDLE --start--> RUN. RUN --halt--> HALTED. HALTED --start--> RUN. halt is ignored outside RUN; start is ignored in RUN.
- Output mapping:
  - imem_addr = pc.
  - imem_en = (state==RUN) & ~stall.
  - op = op_valid ? imem_rdata : BUBBLE_OP (combinational mux).
- issue = op_valid & ~stall. Only on an issue cycle may pc_we act and does issued_cnt increment. issued_cnt wraps 16'hFFFF -> 0.
- RUN, stall=0, no redirect:
  - pc <= pc+1 (mod 64, 63 wraps to 0).
  - op_valid <= 1, op_pc <= pc.
- RUN, stall=1:
  - pc, op_valid and op_pc hold.
  - imem_en=0, so the memory holds imem_rdata and op is stable.
- Redirect (issue & pc_we):
  - pc <= pc_in.
  - op_valid <= 0 next cycle; the sequentially fetched word is flushed as one bubble.
  - The target op is valid 2 cycles after the redirect cycle.
  - pc_we with op_valid=0 or stall=1 is ignored.
- Halt in RUN:
  - Current op still issues if stall=0 (counted, its redirect honoured).
  - pc is not incremented (loaded with pc_in on redirect). op_valid <= 0, next state HALTED.
  - The in-flight fetch is discarded, and resume refetches pc.
- Halt with stall=1: halt still takes effect. The stalled op is not issued, and op_valid <= 0.
- HALTED/IDLE: pc, op_pc and issued_cnt hold; op_valid=0; imem_en=0.
- Start (from IDLE/HALTED):
  - Cycle N+1: RUN with imem_en=1.
  - Cycle N+2: first valid op at pc. Fill latency is 2 cycles from the start pulse.
- Reset asserted mid-run: immediate return to reset values, with no partial pc update.

Test Plan:
- Reset, start at cycle 0, imem[k]=16'h1000+k, no stall -> op_valid=1 from cycle 2; op_pc 0,1,2,… with op=16'h1000+op_pc; issued_cnt=10 after 10 valid cycles.
- Sequential run through address 63 -> op_pc 62,63,0,1 with no bubble at the wrap.
- op at pc=5 raises pc_we with pc_in=6'd40 -> next cycle op_valid=0, op=BUBBLE_OP; following cycle op_pc=40; issued_cnt excludes the bubble.
- stall held 3 cycles while op_pc=7 -> op, op_pc and issued_cnt frozen, imem_en=0; after release op_pc advances to 8 with no duplicate issue.
- halt while op_pc=12 (valid) -> op 12 counted, then op_valid=0 and running=0; start 4 cycles later -> first valid op is op_pc=13 two cycles after start.
- rst_n pulsed low mid-run asynchronously (between clock edges) -> op_valid=0, imem_en=0, issued_cnt=0 immediately; after release pc=START_PC, state IDLE until start.
